step_pulse_gen: RTL and testbench

//  Fast-domain receiver for a slow clock or manual step signal (scaled clock

---
 rtl/step_pulse_gen.sv | 125 ++++++++++++
 tb/tb_step_pulse_gen.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/step_pulse_gen.sv
// -----------------------------------------------------------------------------
// step_pulse_gen
//
// Purpose:
//   Fast-domain receiver for a slow clock or manual step signal (scaled clock
//   output, push-button or switch). The asynchronous input is brought into the
//   inclk domain through a two-flop synchroniser and then debounced. Each
//   accepted rising edge produces a single inclk-wide step pulse. The core uses
//   that pulse as a clock enable, so it stays on the one fast clock instead of
//   running from a divided clock.
//
// Parameters:
//   DEBOUNCE    consecutive inclk cycles the synchronised input must hold a new
//               level before it is accepted (legal range 1..65535)
//   CNT_W       width of step_count
//
// Ports:
//   inclk       in   1      system clock
//   rst_n       in   1      asynchronous reset, active low
//   slow_in     in   1      asynchronous slow clock / button level
//   ena         in   1      step enable; low = track the level, no pulses
//   step        out  1      one-cycle pulse on each accepted rising edge while ena
//   level       out  1      debounced, synchronised level of slow_in
//   step_count  out  CNT_W  number of step pulses issued, wraps modulo 2^CNT_W
// -----------------------------------------------------------------------------
module step_pulse_gen #(
    parameter logic [15:0] DEBOUNCE = 16'd50000,
    parameter int          CNT_W    = 16
) (
    input  logic             inclk,
    input  logic             rst_n,
    input  logic             slow_in,
    input  logic             ena,
    output logic             step,
    output logic             level,
    output logic [CNT_W-1:0] step_count
);

    localparam int          SYNC_STAGES = 2;
    // Terminal count of the debounce counter; the accept happens on the edge
    // that would otherwise move the counter past this value.
    localparam logic [15:0] DEB_LAST    = DEBOUNCE - 16'd1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // -------------------------------------------------------------------------
    // Synchroniser: sync_reg[0] is s1, sync_reg[SYNC_STAGES-1] is s2. Only the
    // last stage is used downstream; nothing else looks at slow_in.
    // -------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_reg;
    logic [SYNC_STAGES-1:0] sync_next;

    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                assign sync_next[gi] = slow_in;
            end else begin : g_chain
                assign sync_next[gi] = sync_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge inclk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= sync_next;
        end
    end

    logic s2;
    assign s2 = sync_reg[SYNC_STAGES-1];

    // -------------------------------------------------------------------------
    // Debounce, step pulse and step counter
    // -------------------------------------------------------------------------
    logic [15:0]      deb_cnt_reg,    deb_cnt_next;
    logic             level_reg,      level_next;
    logic             step_reg,       step_next;
    logic [CNT_W-1:0] step_count_reg, step_count_next;

    always_comb begin
        deb_cnt_next    = deb_cnt_reg;
        level_next      = level_reg;
        step_next       = 1'b0;
        step_count_next = step_count_reg;

        if (s2 == level_reg) begin
            // Input agrees with the accepted level: any partial run of the
            // opposite level was a glitch and is thrown away entirely.
            deb_cnt_next = 16'd0;
        end else if (deb_cnt_reg == DEB_LAST) begin
            level_next   = s2;
            deb_cnt_next = 16'd0;
            // ena only matters on this edge; a rise accepted while disabled
            // is lost for good, and falling accepts never pulse.
            if (s2 && ena) begin
                step_next       = 1'b1;
                step_count_next = step_count_reg + CNT_ONE;
            end
        end else begin
            deb_cnt_next = deb_cnt_reg + 16'd1;
        end
    end

    // After an accept, level equals s2, so the next edge cannot accept a rise
    // again; step therefore never stays high for two consecutive cycles.
    always_ff @(posedge inclk or negedge rst_n) begin
        if (!rst_n) begin
            deb_cnt_reg    <= 16'd0;
            level_reg      <= 1'b0;
            step_reg       <= 1'b0;
            step_count_reg <= '0;
        end else begin
            deb_cnt_reg    <= deb_cnt_next;
            level_reg      <= level_next;
            step_reg       <= step_next;
            step_count_reg <= step_count_next;
        end
    end

    assign step       = step_reg;
    assign level      = level_reg;
    assign step_count = step_count_reg;

endmodule

// File: tb/tb_step_pulse_gen.sv
// -----------------------------------------------------------------------------
// tb_step_pulse_gen
//
// Directed bench for step_pulse_gen with DEBOUNCE=4, CNT_W=4. Inputs are driven
// and outputs sampled on the falling edge of inclk. Expected values are derived
// by hand from the input timing: a level presented before rising edge k reaches
// s2 after edge k+1 and is accepted after edge k+5.
// -----------------------------------------------------------------------------
module tb_step_pulse_gen;

    logic       inclk;
    logic       rst_n;
    logic       slow_in;
    logic       ena;
    logic       step;
    logic       level;
    logic [3:0] step_count;

    int tests_run;
    int tests_failed;

    step_pulse_gen #(
        .DEBOUNCE (16'd4),
        .CNT_W    (4)
    ) dut (
        .inclk      (inclk),
        .rst_n      (rst_n),
        .slow_in    (slow_in),
        .ena        (ena),
        .step       (step),
        .level      (level),
        .step_count (step_count)
    );

    initial inclk = 1'b0;
    always #5 inclk = ~inclk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic e_step,
                              input logic e_level, input logic [3:0] e_cnt);
        check_val({tag, " step"},  {31'd0, step},  {31'd0, e_step});
        check_val({tag, " level"}, {31'd0, level}, {31'd0, e_level});
        check_val({tag, " count"}, {28'd0, step_count}, {28'd0, e_cnt});
    endtask

    task automatic next_cycle;
        @(negedge inclk);
    endtask

    // One full rise/fall of slow_in with ena high: pulse after edge k+5,
    // falling accept after the matching edge on the way down.
    task automatic do_pulse(input logic [3:0] exp_cnt, input logic [3:0] prev_cnt);
        slow_in = 1'b1;
        for (int j = 0; j < 7; j++) begin
            next_cycle();
            check_outs($sformatf("pulse%0d rise k+%0d", exp_cnt, j),
                       (j == 5), (j >= 5), (j >= 5) ? exp_cnt : prev_cnt);
        end
        slow_in = 1'b0;
        for (int j = 0; j < 7; j++) begin
            next_cycle();
            check_outs($sformatf("pulse%0d fall k+%0d", exp_cnt, j),
                       1'b0, (j < 5), exp_cnt);
        end
        $display("[TB] pulse issued, step_count=%0d (expected %0d)", step_count, exp_cnt);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        slow_in      = 1'b0;
        ena          = 1'b0;

        // 1. Reset state and idle after release
        repeat (3) next_cycle();
        check_outs("reset", 1'b0, 1'b0, 4'd0);
        rst_n = 1'b1;
        for (int j = 0; j < 20; j++) begin
            next_cycle();
            check_outs($sformatf("idle c%0d", j), 1'b0, 1'b0, 4'd0);
        end
        $display("[TB] idle after reset checked");

        // 2. First qualified rise: exact latency, single-cycle pulse
        ena     = 1'b1;
        slow_in = 1'b1;
        for (int j = 0; j < 7; j++) begin
            next_cycle();
            check_outs($sformatf("rise k+%0d", j), (j == 5), (j >= 5),
                       (j >= 5) ? 4'd1 : 4'd0);
        end
        $display("[TB] first rise accepted, step_count=%0d", step_count);

        // 3. Three-cycle low glitch while level is 1 is discarded
        slow_in = 1'b0;
        repeat (3) next_cycle();
        slow_in = 1'b1;
        for (int j = 0; j < 10; j++) begin
            next_cycle();
            check_outs($sformatf("glitch c%0d", j), 1'b0, 1'b1, 4'd1);
        end
        // A genuine fall must still need the full debounce time, which only
        // holds if the counter went back to zero after the glitch.
        slow_in = 1'b0;
        for (int j = 0; j < 7; j++) begin
            next_cycle();
            check_outs($sformatf("fall k+%0d", j), 1'b0, (j < 5), 4'd1);
        end
        $display("[TB] glitch filtered, fall accepted");

        // 4. Rise accepted while ena=0: level follows, no pulse, no replay
        ena     = 1'b0;
        slow_in = 1'b1;
        for (int j = 0; j < 7; j++) begin
            next_cycle();
            check_outs($sformatf("noena k+%0d", j), 1'b0, (j >= 5), 4'd1);
        end
        ena = 1'b1;
        for (int j = 0; j < 8; j++) begin
            next_cycle();
            check_outs($sformatf("ena_late c%0d", j), 1'b0, 1'b1, 4'd1);
        end
        slow_in = 1'b0;
        repeat (7) next_cycle();
        check_outs("noena fall", 1'b0, 1'b0, 4'd1);
        $display("[TB] disabled rise tracked without pulse");

        // 5. Fifteen more pulses: count runs 2..15 then wraps to 0
        for (int n = 2; n <= 16; n++) begin
            logic [4:0] nn;
            logic [4:0] pp;
            nn = 5'(n);
            pp = 5'(n - 1);
            do_pulse(nn[3:0], pp[3:0]);
        end

        // 6. Async reset in the middle of a debounce
        do_pulse(4'd1, 4'd0);
        slow_in = 1'b1;
        repeat (4) next_cycle();   // deb_cnt has reached 2
        check_outs("pre-rst", 1'b0, 1'b0, 4'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_outs("async rst", 1'b0, 1'b0, 4'd0);
        repeat (2) next_cycle();
        check_outs("in rst", 1'b0, 1'b0, 4'd0);
        rst_n = 1'b1;
        for (int j = 0; j < 7; j++) begin
            next_cycle();
            check_outs($sformatf("post-rst k+%0d", j), (j == 5), (j >= 5),
                       (j >= 5) ? 4'd1 : 4'd0);
        end
        $display("[TB] reset discarded pending edge, rise re-accepted");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
